// File: rtl/hazard_sched_pkg.sv
// hazard_sched_pkg: opcodes, forwarding codes, FSM states and shadow entry type
package hazard_sched_pkg;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b10;
   localparam logic [1:0] FWD_WB  = 2'b01;

   typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

   // unused source fields are zeroed so they can never match a nonzero rd
   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       regwrite;
      logic       memread;
   } entry_t;

   function automatic logic hit(input entry_t e, input logic [4:0] rs);
      return e.valid && e.regwrite && e.rd != 5'd0 && e.rd == rs;
   endfunction
endpackage

// File: rtl/hazard_sched_if.sv
// hazard_sched_if: pipeline-side control bundle of the hazard scheduler
interface hazard_sched_if #(parameter int CNT_W = 16);
   logic [31:0]      id_instruc;
   logic             id_valid;
   logic             ex_branch_taken;
   logic             dmem_req;
   logic             dmem_ready;
   logic             pc_write;
   logic             ifid_write;
   logic             ifid_flush;
   logic             idex_bubble;
   logic             freeze;
   logic [1:0]       fwd_a;
   logic [1:0]       fwd_b;
   logic             mem_err;
   logic [CNT_W-1:0] stall_count;

   modport master (
      output id_instruc, id_valid, ex_branch_taken, dmem_req, dmem_ready,
      input  pc_write, ifid_write, ifid_flush, idex_bubble, freeze, fwd_a, fwd_b, mem_err, stall_count
   );

   modport slave (
      input  id_instruc, id_valid, ex_branch_taken, dmem_req, dmem_ready,
      output pc_write, ifid_write, ifid_flush, idex_bubble, freeze, fwd_a, fwd_b, mem_err, stall_count
   );
endinterface

// File: rtl/hazard_decode.sv
// hazard_decode: splits the ID instruction into a shadow entry with use flags applied
module hazard_decode
   import hazard_sched_pkg::*;
(
   input  logic [31:0] instruc,
   input  logic        valid,
   output entry_t      ent
);
   logic [6:0] opcode;
   logic       use1;
   logic       use2;
   logic       unused_bits;

   assign opcode      = instruc[6:0];
   assign use1        = !(opcode inside {OP_LUI, OP_AUIPC, OP_JAL});
   assign use2        = opcode inside {OP_REG, OP_STORE, OP_BRANCH};
   assign unused_bits = ^{instruc[31:25], instruc[14:12]};

   // build the entry; an invalid slot is all zeros
   always_comb begin
      ent = '0;
      if (valid) begin
         ent.valid    = 1'b1;
         ent.rd       = instruc[11:7];
         ent.rs1      = use1 ? instruc[19:15] : 5'd0;
         ent.rs2      = use2 ? instruc[24:20] : 5'd0;
         ent.regwrite = !(opcode inside {OP_STORE, OP_BRANCH});
         ent.memread  = opcode == OP_LOAD;
      end
   end
endmodule

// File: rtl/hazard_sched.sv
// hazard_sched: stall/flush/freeze sequencing and EX forwarding for the 5-stage pipe
module hazard_sched
   import hazard_sched_pkg::*;
#(
   parameter int MAX_WAIT = 16,
   parameter int CNT_W    = 16
) (
   input logic           clk,
   input logic           reset,
   hazard_sched_if.slave bus
);
   localparam int WW = $clog2(MAX_WAIT + 1);
   localparam logic [WW-1:0] LAST = WW'(MAX_WAIT - 1);

   state_t           state, state_nxt;
   logic [WW-1:0]    wcnt, wcnt_nxt;
   logic             err, err_nxt;
   logic             frz, flush, stall, load_use;
   entry_t           id_ent, ex, mem, wb;
   logic [CNT_W-1:0] scnt;

   hazard_decode u_dec (.instruc(bus.id_instruc), .valid(bus.id_valid), .ent(id_ent));

   // hazard detection with freeze > flush > load-use priority
   always_comb begin
      load_use = ex.valid && ex.memread && ex.rd != 5'd0 &&
                 (id_ent.rs1 == ex.rd || id_ent.rs2 == ex.rd);
      frz      = state != RUN || (bus.dmem_req && !bus.dmem_ready);
      flush    = !frz && bus.ex_branch_taken;
      stall    = !frz && !bus.ex_branch_taken && load_use;
   end

   assign bus.freeze      = frz;
   assign bus.pc_write    = !frz && !stall;
   assign bus.ifid_write  = !frz && !stall;
   assign bus.ifid_flush  = flush;
   assign bus.idex_bubble = flush || stall;
   assign bus.fwd_a       = hit(mem, ex.rs1) ? FWD_MEM : hit(wb, ex.rs1) ? FWD_WB : FWD_RF;
   assign bus.fwd_b       = hit(mem, ex.rs2) ? FWD_MEM : hit(wb, ex.rs2) ? FWD_WB : FWD_RF;
   assign bus.mem_err     = err;
   assign bus.stall_count = scnt;

   // dmem wait sequencer: counts wait cycles and traps into ERR on timeout
   always_comb begin
      state_nxt = state;
      wcnt_nxt  = wcnt;
      err_nxt   = err;
      if (state == RUN && bus.dmem_req && !bus.dmem_ready) begin
         state_nxt = MEM_WAIT;
         wcnt_nxt  = WW'(1);
      end else if (state == MEM_WAIT) begin
         if (bus.dmem_ready) state_nxt = RUN;
         else if (wcnt >= LAST) begin
            state_nxt = ERR;
            err_nxt   = 1'b1;
            wcnt_nxt  = WW'(MAX_WAIT);
         end else wcnt_nxt = wcnt + WW'(1);
      end
   end

   // FSM, wait counter, sticky error and saturating stall counter
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= RUN;
         wcnt  <= '0;
         err   <= 1'b0;
         scnt  <= '0;
      end else begin
         state <= state_nxt;
         wcnt  <= wcnt_nxt;
         err   <= err_nxt;
         scnt  <= (stall && scnt != '1) ? scnt + CNT_W'(1) : scnt;
      end
   end

   // shadow EX/MEM/WB advance unless frozen; flush and stall inject a bubble
   always_ff @(posedge clk) begin
      if (!reset) begin
         ex  <= '0;
         mem <= '0;
         wb  <= '0;
      end else if (!frz) begin
         ex  <= (flush || stall) ? '0 : id_ent;
         mem <= ex;
         wb  <= mem;
      end
   end
endmodule

// File: tb/tb_hazard_sched.sv
// tb_hazard_sched: directed and random checks against an instruction-level reference model
module tb_hazard_sched;
   localparam int MAX_WAIT = 4;
   localparam int CNT_W    = 4;
   localparam int SAT      = (1 << CNT_W) - 1;

   localparam logic [6:0] T_LOAD = 7'h03;
   localparam logic [6:0] T_REG  = 7'h33;

   typedef struct {
      bit v;
      int rd;
      int rs1;
      int rs2;
      bit rw;
      bit mr;
   } m_ent;

   logic clk = 1'b0;
   logic reset;
   int   n_tests = 0;
   int   n_fail  = 0;

   logic [6:0] ops [9] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};

   m_ent ex, mem, wb, idm;
   bit   in_wait, err;
   int   waited, stalls;
   bit   e_frz, e_flush, e_stall, c_rst, c_req, c_rdy;

   hazard_sched_if #(.CNT_W(CNT_W)) bif ();

   hazard_sched #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(bif));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // instruction-level decode from the ISA rules; -1 marks an unused source
   function automatic m_ent mdec(input logic [31:0] ins, input bit v);
      m_ent e;
      logic [6:0] op = ins[6:0];
      e.v   = v;
      e.rd  = int'(ins[11:7]);
      e.rs1 = (v && !(op inside {7'h37, 7'h17, 7'h6f})) ? int'(ins[19:15]) : -1;
      e.rs2 = (v && (op inside {7'h33, 7'h23, 7'h63})) ? int'(ins[24:20]) : -1;
      e.rw  = !(op inside {7'h23, 7'h63});
      e.mr  = op == 7'h03;
      return e;
   endfunction

   function automatic bit produces(input m_ent p, input int rs);
      return p.v && p.rw && p.rd != 0 && p.rd == rs;
   endfunction

   function automatic logic [31:0] mfwd(input int rs);
      if (rs < 0) return 0;
      if (produces(mem, rs)) return 2;
      if (produces(wb, rs)) return 1;
      return 0;
   endfunction

   function automatic logic [31:0] enc(input logic [6:0] op, input int rd, input int rs1, input int rs2);
      return {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), op};
   endfunction

   function automatic logic [31:0] rnd_ins();
      logic [31:0] i = $urandom;
      i[6:0]   = ($urandom_range(9) == 0) ? 7'($urandom) : ops[$urandom_range(8)];
      i[11:7]  = 5'($urandom_range(3));
      i[19:15] = 5'($urandom_range(3));
      i[24:20] = 5'($urandom_range(3));
      return i;
   endfunction

   task automatic drive(input logic [31:0] ins, input bit v, input bit tk, input bit rq, input bit rdy, input bit rn);
      @(negedge clk);
      bif.id_instruc      = ins;
      bif.id_valid        = v;
      bif.ex_branch_taken = tk;
      bif.dmem_req        = rq;
      bif.dmem_ready      = rdy;
      reset               = rn;
      c_rst = rn; c_req = rq; c_rdy = rdy;
      #1;
      idm     = mdec(ins, v);
      e_frz   = err || in_wait || (rq && !rdy);
      e_flush = !e_frz && tk;
      e_stall = !e_frz && !tk && ex.v && ex.mr && ex.rd != 0 && (idm.rs1 == ex.rd || idm.rs2 == ex.rd);
      check("freeze", bif.freeze, e_frz);
      check("pc_write", bif.pc_write, !e_frz && !e_stall);
      check("ifid_write", bif.ifid_write, !e_frz && !e_stall);
      check("ifid_flush", bif.ifid_flush, e_flush);
      check("idex_bubble", bif.idex_bubble, e_flush || e_stall);
      check("fwd_a", bif.fwd_a, mfwd(ex.rs1));
      check("fwd_b", bif.fwd_b, mfwd(ex.rs2));
      check("mem_err", bif.mem_err, err);
      check("stall_count", bif.stall_count, stalls);
   endtask

   task automatic model_clear();
      ex = mdec(0, 0); mem = ex; wb = ex;
      in_wait = 0; err = 0; waited = 0; stalls = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      if (!c_rst) model_clear();
      else begin
         if (!e_frz) begin
            wb  = mem;
            mem = ex;
            ex  = (e_flush || e_stall) ? mdec(0, 0) : idm;
         end
         if (e_stall && stalls < SAT) stalls++;
         if (in_wait) begin
            if (c_rdy) in_wait = 0;
            else begin
               waited++;
               if (waited >= MAX_WAIT) begin
                  in_wait = 0;
                  err = 1;
               end
            end
         end else if (!err && c_req && !c_rdy) begin
            in_wait = 1;
            waited = 1;
         end
      end
   endtask

   task automatic go(input logic [31:0] ins);
      drive(ins, 1, 0, 0, 0, 1);
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 1);
   endtask

   initial begin
      reset = 1'b0;
      bif.id_instruc = '0; bif.id_valid = 0; bif.ex_branch_taken = 0;
      bif.dmem_req = 0; bif.dmem_ready = 0;
      model_clear();
      repeat (2) @(posedge clk);
      // reset values
      idle();
      check("rst_pc_write", bif.pc_write, 1);
      check("rst_freeze", bif.freeze, 0);
      check("rst_count", bif.stall_count, 0);
      tick();
      // load-use: lw x5 then add x6,x5,x2
      go(enc(T_LOAD, 5, 1, 0)); tick();
      go(enc(T_REG, 6, 5, 2));
      check("lu_pc_write", bif.pc_write, 0);
      check("lu_bubble", bif.idex_bubble, 1);
      tick();
      go(enc(T_REG, 6, 5, 2));
      check("lu_count", bif.stall_count, 1);
      check("lu_single", bif.pc_write, 1);
      tick();
      idle();
      check("lu_fwd_wb", bif.fwd_a, 2'b01);
      tick();
      // double forward, MEM beats WB
      go(enc(T_REG, 3, 1, 2)); tick();
      go(enc(T_REG, 3, 3, 4)); tick();
      go(enc(T_REG, 7, 3, 3)); tick();
      idle();
      check("dbl_fwd_a", bif.fwd_a, 2'b10);
      check("dbl_fwd_b", bif.fwd_b, 2'b10);
      tick();
      // branch taken together with load-use
      go(enc(T_LOAD, 5, 1, 0)); tick();
      drive(enc(T_REG, 6, 5, 2), 1, 1, 0, 0, 1);
      check("br_flush", bif.ifid_flush, 1);
      check("br_bubble", bif.idex_bubble, 1);
      check("br_pc_write", bif.pc_write, 1);
      tick();
      idle();
      check("br_count", bif.stall_count, 1);
      tick();
      // dmem wait of three cycles then ready
      go(enc(T_REG, 3, 1, 2)); tick();
      for (int i = 0; i < 3; i++) begin
         drive(enc(T_REG, 7, 3, 3), 1, 0, 1, 0, 1);
         check("wait_freeze", bif.freeze, 1);
         tick();
      end
      drive(enc(T_REG, 7, 3, 3), 1, 0, 1, 1, 1);
      check("wait_last_freeze", bif.freeze, 1);
      tick();
      idle();
      check("wait_resume", bif.freeze, 0);
      tick();
      // timeout then reset
      for (int i = 0; i < MAX_WAIT; i++) begin
         drive(0, 0, 0, 1, 0, 1);
         tick();
      end
      idle();
      check("to_mem_err", bif.mem_err, 1);
      check("to_freeze", bif.freeze, 1);
      tick();
      drive(0, 0, 0, 0, 0, 0); tick();
      idle();
      check("to_rst_err", bif.mem_err, 0);
      check("to_rst_freeze", bif.freeze, 0);
      check("to_rst_pc", bif.pc_write, 1);
      tick();
      // rd = x0 never hazards
      go(enc(T_LOAD, 0, 1, 0)); tick();
      go(enc(T_REG, 6, 0, 0));
      check("x0_pc_write", bif.pc_write, 1);
      check("x0_bubble", bif.idex_bubble, 0);
      tick();
      idle();
      check("x0_fwd_a", bif.fwd_a, 0);
      check("x0_fwd_b", bif.fwd_b, 0);
      tick();
      // saturate the stall counter
      for (int i = 0; i < 20; i++) begin
         go(enc(T_LOAD, 5, 1, 0)); tick();
         go(enc(T_REG, 6, 5, 2)); tick();
         go(enc(T_REG, 6, 5, 2)); tick();
      end
      idle();
      check("sat_count", bif.stall_count, SAT);
      tick();
      // random traffic
      for (int n = 0; n < 800; n++) begin
         bit rn = !(err && $urandom_range(2) == 0) && $urandom_range(199) != 0;
         drive(rnd_ins(), $urandom_range(9) != 0, $urandom_range(6) == 0,
               $urandom_range(4) == 0, $urandom_range(1) == 0, rn);
         tick();
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/hazard_sched.md
Name: hazard_sched

Overview:
- Hazard scheduler for the 5-stage RISC-V pipeline; sits beside ID/EX and sequences stalls, flushes, freezes and forwarding.
- Keeps its own shadow pipeline (EX/MEM/WB) of destination and source register fields, advanced in lockstep with the datapath registers.
- Decodes the ID-stage instruction word into fields internally, detects load-use and control hazards, and freezes the whole pipe during data-memory wait states.

Parameters:
- MAX_WAIT, 16, dmem wait cycles tolerated before the timeout error is raised.
- CNT_W, 16, width of the saturating load-use stall counter.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  synchronous active-low reset.
- id_instruc  in  32  instruction word in IF/ID.
- id_valid  in  1  IF/ID holds a real instruction.
- ex_branch_taken  in  1  branch/jump resolved taken in EX this cycle.
- dmem_req  in  1  MEM stage is accessing data memory.
- dmem_ready  in  1  data memory completes the access this cycle.
- pc_write  out  1  PC may update.
- ifid_write  out  1  IF/ID may load.
- ifid_flush  out  1  IF/ID loads a NOP.
- idex_bubble  out  1  ID/EX loads a NOP.
- freeze  out  1  hold every pipeline register.
- fwd_a  out  2  EX operand A source: 00 regfile, 10 MEM, 01 WB.
- fwd_b  out  2  EX operand B source, same encoding.
- mem_err  out  1  sticky dmem timeout flag.
- stall_count  out  CNT_W  load-use stall cycles, saturating.

Behaviour:
- Reset (reset=0 at a clock edge):
  - All shadow entries invalid; FSM goes to RUN; wait counter, stall_count and mem_err are cleared.
  - The resulting outputs are pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0, freeze=0, fwd_a=fwd_b=00.
  - Reset mid-MEM_WAIT or in ERR returns to RUN with these values.
- Shadow entry fields: valid, rd, rs1, rs2, regwrite, memread. The ID-side entry is decoded from id_instruc and gated by id_valid.
- Source use: rs1 is unused for LUI, AUIPC and JAL. rs2 is used only by R-type, STORE and BRANCH. regwrite is 0 for STORE and BRANCH. memread is 1 for LOAD only. An entry with rd=0 never creates a hazard.
- Outputs are combinational from shadow state and inputs (zero-cycle latency). The shadow advances one stage per edge unless freeze=1.
- Priority, highest first: freeze, then branch flush, then load-use stall.
- Freeze:
  - Condition: FSM in MEM_WAIT or ERR, or in RUN with dmem_req=1 and dmem_ready=0.
  - Effect: freeze=1, pc_write=0, ifid_write=0, no flush or bubble; the shadow holds.
- Branch flush:
  - Condition: ex_branch_taken=1 and not frozen.
  - Effect: ifid_flush=1, idex_bubble=1, pc_write=1. The EX shadow receives an invalid entry and any load-use stall is suppressed.
- Load-use stall:
  - Condition: EX entry valid, memread=1, rd!=0, and rd matches a used rs1/rs2 of the ID entry.
  - Effect: pc_write=0, ifid_write=0, idex_bubble=1; the EX shadow receives a bubble.
  - stall_count increments by 1 per stall cycle and saturates at all-ones.
- Forwarding for the EX entry, per operand:
  - MEM match (valid, regwrite, rd!=0, rd==rs) gives 10; otherwise a WB match gives 01; otherwise 00.
  - MEM wins when both match.
  - Forwarding outputs remain valid and stable while frozen.
- FSM states RUN, MEM_WAIT, ERR:
  - RUN to MEM_WAIT when dmem_req=1 and dmem_ready=0; the wait counter is loaded with 1.
  - MEM_WAIT to RUN on dmem_ready=1. Freeze is still 1 in that cycle; the pipe advances on the following edge.
  - MEM_WAIT increments the wait counter each cycle. When the counter reaches MAX_WAIT without ready, the FSM goes to ERR and mem_err is set.
  - ERR holds freeze=1 until reset.
- The wait counter is sized $clog2(MAX_WAIT+1) and never wraps.

Decomposition:
- Shared package holds:
  - opcode constants: OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_REG;
  - forwarding encodings FWD_RF, FWD_MEM, FWD_WB;
  - FSM state encodings.
- One sub-module, hazard_decode: a combinational field split of id_instruc into opcode/rd/rs1/rs2, plus the use/regwrite/memread flags. The sequencing and forwarding stay in the top.

Test Plan:
- Load-use: `lw x5,0(x1)` then `add x6,x5,x2` → exactly one cycle of pc_write=0, idex_bubble=1, stall_count 0→1. Next cycle fwd_a=01 for the add.
- Double forward: `add x3,x1,x2`, `sub x3,x3,x4`, `and x7,x3,x3` → in the and's EX cycle, fwd_a=fwd_b=10 (MEM wins over WB).
- Branch plus load-use in the same cycle: ex_branch_taken=1 with a load-use condition → ifid_flush=1, idex_bubble=1, pc_write=1, stall_count unchanged.
- Memory wait: dmem_req=1 with dmem_ready low for 3 cycles → freeze=1 for 4 cycles, shadow and fwd held; pipe resumes after ready.
- Timeout and reset: MAX_WAIT=4 with ready never asserted → mem_err=1 after 4 cycles and freeze stuck high. Then reset=0 for 1 edge → mem_err=0, freeze=0, pc_write=1.
- rd=x0: `lw x0,...` followed by a use of x0 → no stall, and fwd_a=fwd_b=00.
